// File: rtl/rx78_vram_if.sv
// rx78_vram_if: Z80 bus, video fetch port and register outputs of the VRAM arbiter.
// Latency: none, wires only.
// Backpressure: cpu_wait_n flows slave->master; the video side has none.
interface rx78_vram_if #(
   parameter int AW      = 13,
   parameter int PLANES  = 6,
   parameter int NUM_PAL = 6
);
   logic [15:0]           cpu_addr;
   logic [7:0]            cpu_dout;
   logic [7:0]            cpu_din;
   logic                  cpu_mreq_n;
   logic                  cpu_iorq_n;
   logic                  cpu_rd_n;
   logic                  cpu_wr_n;
   logic                  cpu_m1_n;
   logic                  vram_sel;
   logic                  cpu_wait_n;
   logic                  cpu_int_n;
   logic                  vid_req;
   logic [AW-1:0]         vid_addr;
   logic [PLANES*8-1:0]   vid_data;
   logic                  vid_valid;
   logic                  vb;
   logic [NUM_PAL*8-1:0]  pal;
   logic [7:0]            mask;

   // CPU, video and timing side
   modport master (
      output cpu_addr, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n,
      output vram_sel, vid_req, vid_addr, vb,
      input  cpu_din, cpu_wait_n, cpu_int_n, vid_data, vid_valid, pal, mask
   );

   // Arbiter side
   modport slave (
      input  cpu_addr, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n,
      input  vram_sel, vid_req, vid_addr, vb,
      output cpu_din, cpu_wait_n, cpu_int_n, vid_data, vid_valid, pal, mask
   );
endinterface

// File: rtl/rx78_vram_arbiter.sv
// rx78_vram_arbiter: banked bit-plane VRAM, bank/palette/mask I/O registers, CPU/video arbitration, vblank interrupt.
// Latency: video data 1 cycle after vid_req; CPU VRAM read data in the cycle after grant; I/O read data 1 cycle.
// Backpressure: video is never stalled; the CPU is held with cpu_wait_n while video owns the plane ports.
module rx78_vram_arbiter #(
   parameter int         PLANES      = 6,
   parameter int         AW          = 13,
   parameter int         NUM_PAL     = 6,
   parameter logic [7:0] IO_RD_BANK  = 8'hF1,
   parameter logic [7:0] IO_WR_BANK  = 8'hF2,
   parameter logic [7:0] IO_PAL_BASE = 8'hF5,
   parameter logic [7:0] IO_MASK     = 8'hFE,
   parameter int         RD_MODE     = 0
) (
   input  logic       clk,
   input  logic       reset,
   rx78_vram_if.slave bus
);

   localparam int         DEPTH   = 1 << AW;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_DONE = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [7:0]            rd_bank_q, rd_bank_d;
   logic [7:0]            wr_bank_q, wr_bank_d;
   logic [7:0]            mask_q, mask_d;
   logic [7:0]            cpu_din_q, cpu_din_d;
   logic [NUM_PAL*8-1:0]  pal_q, pal_d;
   logic [PLANES*8-1:0]   vid_data_q, vid_data_d;
   logic                  vid_valid_q, vid_valid_d;
   logic                  vb_q, vb_d;
   logic                  pending_q, pending_d;

   logic [7:0]            plane_mem [PLANES][DEPTH];
   logic [7:0]            ram_rdat  [PLANES];
   logic [AW-1:0]         ram_addr;
   logic [PLANES-1:0]     ram_we;

   logic                  cpu_req, cpu_grant, io_wr, io_rd, int_ack;
   logic [7:0]            io_port, io_rdat, rd_comb;
   logic                  unused_addr;

   // Bus-cycle qualifiers; nothing is granted while reset is held so an interrupted write never lands
   always_comb begin
      cpu_req   = !bus.cpu_mreq_n && bus.vram_sel && (!bus.cpu_rd_n || !bus.cpu_wr_n);
      cpu_grant = (state_q == ST_IDLE) && cpu_req && !bus.vid_req && !reset;
      io_wr     = !bus.cpu_iorq_n && !bus.cpu_wr_n && bus.cpu_m1_n;
      io_rd     = !bus.cpu_iorq_n && !bus.cpu_rd_n && bus.cpu_m1_n;
      int_ack   = !bus.cpu_m1_n && !bus.cpu_iorq_n;
      io_port   = bus.cpu_addr[7:0];
   end

   // Single shared port per plane: video owns the address whenever it fetches
   always_comb begin
      ram_addr = bus.vid_req ? bus.vid_addr : bus.cpu_addr[AW-1:0];
      for (int p = 0; p < PLANES; p++) begin
         ram_we[p]   = cpu_grant && !bus.cpu_wr_n && wr_bank_q[p];
         ram_rdat[p] = plane_mem[p][ram_addr];
      end
   end

   // Plane storage, deliberately not reset; a CPU write is broadcast to every wr_bank plane
   always_ff @(posedge clk) begin
      for (int p = 0; p < PLANES; p++) begin
         if (ram_we[p]) plane_mem[p][ram_addr] <= bus.cpu_dout;
      end
   end

   // Merge the rd_bank planes into one CPU byte: OR, or lowest selected plane
   always_comb begin
      rd_comb = 8'h00;
      if (RD_MODE == 0) begin
         for (int p = 0; p < PLANES; p++) begin
            if (rd_bank_q[p]) rd_comb = rd_comb | ram_rdat[p];
         end
      end else begin
         for (int p = PLANES - 1; p >= 0; p--) begin
            if (rd_bank_q[p]) rd_comb = ram_rdat[p];
         end
      end
   end

   // I/O register readback mux; unknown ports read as zero
   always_comb begin
      io_rdat = 8'h00;
      if (io_port == IO_RD_BANK) io_rdat = rd_bank_q;
      if (io_port == IO_WR_BANK) io_rdat = wr_bank_q;
      for (int i = 0; i < NUM_PAL; i++) begin
         if (io_port == 8'(IO_PAL_BASE + i)) io_rdat = pal_q[i*8 +: 8];
      end
      if (io_port == IO_MASK) io_rdat = mask_q;
   end

   // I/O register writes, taken on every qualifying edge
   always_comb begin
      rd_bank_d = rd_bank_q;
      wr_bank_d = wr_bank_q;
      mask_d    = mask_q;
      pal_d     = pal_q;
      if (io_wr) begin
         if (io_port == IO_RD_BANK) rd_bank_d = bus.cpu_dout;
         if (io_port == IO_WR_BANK) wr_bank_d = bus.cpu_dout;
         for (int i = 0; i < NUM_PAL; i++) begin
            if (io_port == 8'(IO_PAL_BASE + i)) pal_d[i*8 +: 8] = bus.cpu_dout;
         end
         if (io_port == IO_MASK) mask_d = bus.cpu_dout;
      end
   end

   // CPU access FSM: one commit per bus cycle, DONE holds until the request window closes
   always_comb begin
      state_d   = state_q;
      cpu_din_d = 8'h00;
      case (state_q)
         ST_IDLE: begin
            if (cpu_grant) begin
               state_d   = ST_DONE;
               cpu_din_d = bus.cpu_wr_n ? rd_comb : 8'h00;
            end
         end
         default: begin
            if (bus.cpu_mreq_n || !bus.vram_sel) state_d = ST_IDLE;
            else                                 cpu_din_d = cpu_din_q;
         end
      endcase
      if (io_rd) cpu_din_d = io_rdat;
   end

   // Video capture and latched vblank interrupt; a new edge wins over a same-cycle acknowledge
   always_comb begin
      vid_valid_d = bus.vid_req;
      vid_data_d  = vid_data_q;
      if (bus.vid_req) begin
         for (int p = 0; p < PLANES; p++) vid_data_d[p*8 +: 8] = ram_rdat[p];
      end
      vb_d      = bus.vb;
      pending_d = pending_q;
      if (int_ack)            pending_d = 1'b0;
      if (bus.vb && !vb_q)    pending_d = 1'b1;
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rd_bank_q   <= 8'h00;
         wr_bank_q   <= 8'h00;
         mask_q      <= 8'h00;
         pal_q       <= '0;
         cpu_din_q   <= 8'h00;
         vid_data_q  <= '0;
         vid_valid_q <= 1'b0;
         vb_q        <= 1'b0;
         pending_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_bank_q   <= rd_bank_d;
         wr_bank_q   <= wr_bank_d;
         mask_q      <= mask_d;
         pal_q       <= pal_d;
         cpu_din_q   <= cpu_din_d;
         vid_data_q  <= vid_data_d;
         vid_valid_q <= vid_valid_d;
         vb_q        <= vb_d;
         pending_q   <= pending_d;
      end
   end

   assign bus.cpu_din    = cpu_din_q;
   assign bus.cpu_wait_n = !((state_q == ST_IDLE) && cpu_req && !reset);
   assign bus.cpu_int_n  = !pending_q;
   assign bus.vid_data   = vid_data_q;
   assign bus.vid_valid  = vid_valid_q;
   assign bus.pal        = pal_q;
   assign bus.mask       = mask_q;

   // Upper address bits are decoded outside this block
   assign unused_addr = ^bus.cpu_addr;

endmodule

// File: tb/tb_rx78_vram_arbiter.sv
// tb_rx78_vram_arbiter: directed bench for rx78_vram_arbiter in both read-combine modes.
// A behavioural model (plane arrays, register copies, served flag) is checked every cycle on negedge,
// plus hand-computed literal expectations after each directed sequence.
module tb_rx78_vram_arbiter;

   logic        clk;
   logic        reset;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dout;
   logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, vram_sel;
   logic        vid_req;
   logic [12:0] vid_addr;
   logic        vb;

   int n_tests = 0;
   int n_fail  = 0;
   logic chk_en = 1'b0;

   rx78_vram_if #(.AW(13), .PLANES(6), .NUM_PAL(6)) bus0 ();
   rx78_vram_if #(.AW(13), .PLANES(6), .NUM_PAL(6)) bus1 ();

   assign bus0.cpu_addr = cpu_addr;   assign bus1.cpu_addr = cpu_addr;
   assign bus0.cpu_dout = cpu_dout;   assign bus1.cpu_dout = cpu_dout;
   assign bus0.cpu_mreq_n = mreq_n;   assign bus1.cpu_mreq_n = mreq_n;
   assign bus0.cpu_iorq_n = iorq_n;   assign bus1.cpu_iorq_n = iorq_n;
   assign bus0.cpu_rd_n = rd_n;       assign bus1.cpu_rd_n = rd_n;
   assign bus0.cpu_wr_n = wr_n;       assign bus1.cpu_wr_n = wr_n;
   assign bus0.cpu_m1_n = m1_n;       assign bus1.cpu_m1_n = m1_n;
   assign bus0.vram_sel = vram_sel;   assign bus1.vram_sel = vram_sel;
   assign bus0.vid_req = vid_req;     assign bus1.vid_req = vid_req;
   assign bus0.vid_addr = vid_addr;   assign bus1.vid_addr = vid_addr;
   assign bus0.vb = vb;               assign bus1.vb = vb;

   rx78_vram_arbiter #(.RD_MODE(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
   rx78_vram_arbiter #(.RD_MODE(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]  m_mem [6][8192];
   logic [7:0]  m_rd_bank, m_wr_bank, m_mask, m_din0, m_din1, m_hold0, m_hold1;
   logic [47:0] m_pal, m_vid_data;
   logic        m_vid_valid, m_pending, m_prev_vb, m_served;
   logic        m_req, exp_wait;

   function automatic logic [7:0] combine(input int mode, input logic [7:0] bank, input logic [12:0] a);
      logic [7:0] r;
      bit found;
      r = 8'h00;
      found = 0;
      for (int p = 0; p < 6; p++) begin
         if (bank[p]) begin
            if (mode == 0) r = r | m_mem[p][a];
            else if (!found) begin
               r = m_mem[p][a];
               found = 1;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] io_val(input logic [7:0] port);
      logic [7:0] v;
      v = 8'h00;
      if (port == 8'hF1) v = m_rd_bank;
      if (port == 8'hF2) v = m_wr_bank;
      if (port == 8'hFE) v = m_mask;
      for (int i = 0; i < 6; i++) if (port == 8'(8'hF5 + i)) v = m_pal[i*8 +: 8];
      return v;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_rd_bank = 0; m_wr_bank = 0; m_mask = 0; m_pal = '0;
         m_din0 = 0; m_din1 = 0; m_hold0 = 0; m_hold1 = 0;
         m_vid_data = '0; m_vid_valid = 0; m_pending = 0; m_prev_vb = 0; m_served = 0;
      end else begin
         m_req = !mreq_n && vram_sel && (!rd_n || !wr_n);
         m_vid_valid = vid_req;
         if (vid_req) for (int p = 0; p < 6; p++) m_vid_data[p*8 +: 8] = m_mem[p][vid_addr];
         m_din0 = 0; m_din1 = 0;
         if (!m_served) begin
            if (m_req && !vid_req) begin
               m_served = 1;
               m_hold0 = 0; m_hold1 = 0;
               if (!wr_n) begin
                  for (int p = 0; p < 6; p++) if (m_wr_bank[p]) m_mem[p][cpu_addr[12:0]] = cpu_dout;
               end else begin
                  m_hold0 = combine(0, m_rd_bank, cpu_addr[12:0]);
                  m_hold1 = combine(1, m_rd_bank, cpu_addr[12:0]);
               end
               m_din0 = m_hold0; m_din1 = m_hold1;
            end
         end else if (mreq_n || !vram_sel) begin
            m_served = 0;
         end else begin
            m_din0 = m_hold0; m_din1 = m_hold1;
         end
         if (!iorq_n && !rd_n && m1_n) begin
            m_din0 = io_val(cpu_addr[7:0]);
            m_din1 = m_din0;
         end
         if (!iorq_n && !wr_n && m1_n) begin
            if (cpu_addr[7:0] == 8'hF1) m_rd_bank = cpu_dout;
            if (cpu_addr[7:0] == 8'hF2) m_wr_bank = cpu_dout;
            if (cpu_addr[7:0] == 8'hFE) m_mask = cpu_dout;
            for (int i = 0; i < 6; i++) if (cpu_addr[7:0] == 8'(8'hF5 + i)) m_pal[i*8 +: 8] = cpu_dout;
         end
         if (vb && !m_prev_vb) m_pending = 1;
         else if (!m1_n && !iorq_n) m_pending = 0;
         m_prev_vb = vb;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         exp_wait = !(!reset && !m_served && !mreq_n && vram_sel && (!rd_n || !wr_n));
         chk("wait_n", 64'(bus0.cpu_wait_n), 64'(exp_wait));
         chk("wait_n_m1", 64'(bus1.cpu_wait_n), 64'(exp_wait));
         chk("int_n", 64'(bus0.cpu_int_n), 64'(!m_pending));
         chk("din", 64'(bus0.cpu_din), 64'(m_din0));
         chk("din_m1", 64'(bus1.cpu_din), 64'(m_din1));
         chk("vid_valid", 64'(bus0.vid_valid), 64'(m_vid_valid));
         if (m_vid_valid) chk("vid_data", 64'(bus0.vid_data), 64'(m_vid_data));
         chk("pal", 64'(bus0.pal), 64'(m_pal));
         chk("mask", 64'(bus0.mask), 64'(m_mask));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; m1_n = 1; vram_sel = 0;
      cpu_addr = 16'h0000; cpu_dout = 8'h00;
   endtask

   task automatic io_write(input logic [7:0] port, input logic [7:0] d);
      cpu_addr = {8'h00, port}; cpu_dout = d; iorq_n = 0; wr_n = 0;
      step();
      idle();
   endtask

   task automatic io_read(input logic [7:0] port, output logic [7:0] d);
      cpu_addr = {8'h12, port}; iorq_n = 0; rd_n = 0;
      step();
      d = bus0.cpu_din;
      idle();
      step();
   endtask

   // VRAM access; video fetches for the first vid_cycles cycles. Returns data seen in DONE and wait count.
   task automatic mem_acc(input logic wr, input logic [12:0] a, input logic [7:0] d,
                          input int vid_cycles, input logic [12:0] va,
                          output logic [7:0] r0, output logic [7:0] r1, output int waits);
      int k;
      cpu_addr = 16'hE000 | {3'b000, a}; cpu_dout = d;
      mreq_n = 0; vram_sel = 1; rd_n = wr; wr_n = !wr;
      vid_addr = va; vid_req = (vid_cycles > 0);
      waits = 0; k = 0;
      #1;
      while (!bus0.cpu_wait_n && k < 20) begin
         waits++;
         step();
         k++;
         vid_req = (k < vid_cycles);
         #1;
      end
      chk("acc_reached_done", 64'(bus0.cpu_wait_n), 64'(1));
      r0 = bus0.cpu_din; r1 = bus1.cpu_din;
      step();                  // hold strobes one more cycle in DONE
      vid_req = 0;
      idle();
      step();
   endtask

   logic [7:0] r0, r1, d;
   int         w;

   initial begin
      reset = 1'b1; vb = 0; vid_req = 0; vid_addr = '0;
      idle();
      @(posedge clk);
      chk_en = 1'b1;
      step();
      chk("rst_din", 64'(bus0.cpu_din), 64'(0));
      chk("rst_wait_n", 64'(bus0.cpu_wait_n), 64'(1));
      chk("rst_int_n", 64'(bus0.cpu_int_n), 64'(1));
      chk("rst_pal", 64'(bus0.pal), 64'(0));
      reset = 1'b0;
      step();

      // Initialise the addresses used below in all planes
      io_write(8'hF2, 8'h3F);
      mem_acc(1, 13'h0100, 8'h11, 0, 0, r0, r1, w);
      mem_acc(1, 13'h0200, 8'h00, 0, 0, r0, r1, w);
      mem_acc(1, 13'h0300, 8'h3C, 0, 0, r0, r1, w);

      // Reset in the middle of a broadcast write: nothing commits
      io_write(8'hF2, 8'h3F);
      cpu_addr = 16'hE300; cpu_dout = 8'hFF; mreq_n = 0; vram_sel = 1; wr_n = 0;
      #2 reset = 1'b1;
      step();
      idle();
      #1;
      chk("rst_mid_din", 64'(bus0.cpu_din), 64'(0));
      chk("rst_mid_wait", 64'(bus0.cpu_wait_n), 64'(1));
      chk("rst_mid_vvalid", 64'(bus0.vid_valid), 64'(0));
      chk("rst_mid_vdata", 64'(bus0.vid_data), 64'(0));
      chk("rst_mid_mask", 64'(bus0.mask), 64'(0));
      step();
      reset = 1'b0;
      step();
      io_write(8'hF1, 8'h3F);
      mem_acc(0, 13'h0300, 8'h00, 0, 0, r0, r1, w);
      chk("rst_keep_or", 64'(r0), 64'(8'h3C));
      chk("rst_keep_low", 64'(r1), 64'(8'h3C));

      // Broadcast write to planes 0 and 2
      io_write(8'hF2, 8'h05);
      io_write(8'hF1, 8'h01);
      mem_acc(1, 13'h0100, 8'hA5, 0, 0, r0, r1, w);
      chk("bc_wr_waits", 64'(w), 64'(1));
      mem_acc(0, 13'h0100, 8'h00, 0, 0, r0, r1, w);
      chk("bc_rd_p0", 64'(r0), 64'(8'hA5));
      chk("bc_rd_waits", 64'(w), 64'(1));
      io_write(8'hF1, 8'h02);
      mem_acc(0, 13'h0100, 8'h00, 0, 0, r0, r1, w);
      chk("bc_rd_p1", 64'(r0), 64'(8'h11));
      io_write(8'hF1, 8'h04);
      mem_acc(0, 13'h0100, 8'h00, 0, 0, r0, r1, w);
      chk("bc_rd_p2", 64'(r0), 64'(8'hA5));
      vid_req = 1; vid_addr = 13'h0100;
      step();
      vid_req = 0;
      chk("vid_valid_pulse", 64'(bus0.vid_valid), 64'(1));
      chk("vid_data_bc", 64'(bus0.vid_data), 64'(48'h111111A511A5));
      step();
      chk("vid_valid_end", 64'(bus0.vid_valid), 64'(0));

      // Read combine
      io_write(8'hF2, 8'h01);
      mem_acc(1, 13'h0200, 8'h0F, 0, 0, r0, r1, w);
      io_write(8'hF2, 8'h02);
      mem_acc(1, 13'h0200, 8'hF0, 0, 0, r0, r1, w);
      io_write(8'hF1, 8'h03);
      mem_acc(0, 13'h0200, 8'h00, 0, 0, r0, r1, w);
      chk("comb_or", 64'(r0), 64'(8'hFF));
      chk("comb_low", 64'(r1), 64'(8'h0F));
      io_write(8'hF1, 8'h00);
      mem_acc(0, 13'h0200, 8'h00, 0, 0, r0, r1, w);
      chk("comb_none_or", 64'(r0), 64'(8'h00));
      chk("comb_none_low", 64'(r1), 64'(8'h00));
      io_write(8'hF1, 8'hC2);
      mem_acc(0, 13'h0200, 8'h00, 0, 0, r0, r1, w);
      chk("comb_hibits_or", 64'(r0), 64'(8'hF0));
      chk("comb_hibits_low", 64'(r1), 64'(8'hF0));

      // Contention: video holds the planes for 3 cycles
      io_write(8'hF1, 8'h01);
      mem_acc(0, 13'h0100, 8'h00, 3, 13'h0200, r0, r1, w);
      chk("cont_waits", 64'(w), 64'(4));
      chk("cont_data", 64'(r0), 64'(8'hA5));
      chk("cont_vdata", 64'(bus0.vid_data), 64'(48'h00000000F00F));

      // I/O readback
      io_write(8'hF8, 8'h5A);
      chk("pal3_out", 64'(bus0.pal[31:24]), 64'(8'h5A));
      io_read(8'hF8, d);
      chk("pal3_rd", 64'(d), 64'(8'h5A));
      io_read(8'h10, d);
      chk("unmapped_rd", 64'(d), 64'(8'h00));
      io_write(8'hFE, 8'h81);
      chk("mask_out", 64'(bus0.mask), 64'(8'h81));
      io_read(8'hF2, d);
      chk("wrbank_rd", 64'(d), 64'(8'h02));

      // Interrupt
      vb = 1;
      step();
      chk("int_set", 64'(bus0.cpu_int_n), 64'(0));
      repeat (1000) step();
      chk("int_held", 64'(bus0.cpu_int_n), 64'(0));
      m1_n = 0; iorq_n = 0;
      step();
      idle();
      chk("int_ack", 64'(bus0.cpu_int_n), 64'(1));
      vb = 0;
      step();
      vb = 1; m1_n = 0; iorq_n = 0;
      step();
      idle();
      chk("int_edge_ack", 64'(bus0.cpu_int_n), 64'(0));
      m1_n = 0; iorq_n = 0;
      step();
      idle();
      chk("int_ack2", 64'(bus0.cpu_int_n), 64'(1));
      vb = 0;
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/rx78_vram_arbiter.md
Name: rx78_vram_arbiter

Overview:
Parametrised successor to the RX-78 banked-VRAM/IO glue. Owns PLANES single-port 2^AW x 8 plane memories, the bank/palette/mask I/O registers, CPU-vs-video arbitration with Z80 wait insertion, and a latched vblank interrupt with acknowledge. It sits between the tv80s bus and the gfx block. It replaces the per-plane dual-port RAMs and the single-cycle interrupt pulse.

Parameters:
PLANES, 6, number of bit-plane memories (1..8)
AW, 13, plane address width
NUM_PAL, 6, number of palette registers
IO_RD_BANK, 8'hF1, read-bank select port
IO_WR_BANK, 8'hF2, write-bank select port
IO_PAL_BASE, 8'hF5, first palette port; palette i at IO_PAL_BASE+i
IO_MASK, 8'hFE, mask port
RD_MODE, 0, 0 = OR of selected planes; 1 = lowest-index selected plane only

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_addr  in  16  Z80 address bus
cpu_dout  in  8  Z80 write data
cpu_din  out  8  read data to Z80; 8'h00 when not driving
cpu_mreq_n  in  1  memory request
cpu_iorq_n  in  1  I/O request
cpu_rd_n  in  1  read strobe
cpu_wr_n  in  1  write strobe
cpu_m1_n  in  1  M1 cycle
vram_sel  in  1  top-level decode: cpu_addr lies in the VRAM window
cpu_wait_n  out  1  Z80 wait request
cpu_int_n  out  1  Z80 maskable interrupt
vid_req  in  1  video fetch strobe, one cycle
vid_addr  in  AW  video fetch address
vid_data  out  PLANES*8  plane bytes, plane 0 in bits [7:0]
vid_valid  out  1  vid_data valid pulse
vb  in  1  vertical blank
pal  out  NUM_PAL*8  palette registers, palette 0 in bits [7:0]
mask  out  8  mask register

Behaviour:
- Reset (async): rd_bank, wr_bank, pal, mask, cpu_din, vid_data = 0; vid_valid = 0; cpu_int_n = 1; cpu_wait_n = 1; state = IDLE. Plane contents are not cleared. Reset during an access aborts it; no write commits.
- I/O write: when iorq_n=0, wr_n=0, m1_n=1 and cpu_addr[7:0] matches, the register loads cpu_dout on that edge. A register loads on every qualifying edge.
- I/O read: when iorq_n=0, rd_n=0, m1_n=1 and the port matches, cpu_din returns the register value registered one cycle later. Unmatched ports return 8'h00. Bank registers keep all 8 bits; bits >= PLANES are ignored for access.
- Video port: on vid_req=1 all planes read vid_addr. vid_data is updated and vid_valid=1 on the next cycle. Video is never stalled and always wins arbitration.
- CPU access FSM, active while mreq_n=0 && vram_sel && (rd_n=0 || wr_n=0):
  IDLE: If vid_req=1, the FSM holds IDLE with cpu_wait_n=0. Otherwise it grants. A write writes cpu_dout at cpu_addr[AW-1:0] into every plane whose wr_bank bit is set (broadcast). A read reads every plane whose rd_bank bit is set. The FSM then goes to DONE. cpu_wait_n=0 in the grant cycle.
  DONE: cpu_wait_n=1. On a read, cpu_din holds the combined data (RD_MODE 0: OR; RD_MODE 1: lowest-index set plane; rd_bank planes all zero: 8'h00). The FSM returns to IDLE when mreq_n=1 or vram_sel=0, and cpu_din then returns to 8'h00.
  - cpu_wait_n is combinational: 0 in IDLE while a request is pending, 1 otherwise.
  - An access commits exactly once per bus cycle, however long the strobes are held.
- Interrupt: vb is registered. A rising edge (vb=1, prior=0) sets pending, and cpu_int_n = ~pending. pending clears on interrupt acknowledge (m1_n=0 && iorq_n=0). An edge in the same cycle as an acknowledge leaves pending set. pending stays set until acknowledged, with no timeout.

Test Plan:
- Reset state: assert reset mid-write with wr_bank=8'h3F -> all outputs at reset values; a subsequent read of that address returns the pre-write contents.
- Broadcast write: write ports F2=8'h05 and F1=8'h01, then write 8'hA5 to a VRAM address -> planes 0 and 2 hold 8'hA5 and plane 1 is unchanged. A read returns 8'hA5 in DONE, cpu_wait_n=0 for exactly one cycle.
- Read combine: planes 0/1 hold 8'h0F/8'hF0 and rd_bank=8'h03 -> RD_MODE 0 returns 8'hFF, RD_MODE 1 returns 8'h0F. rd_bank=0 returns 8'h00.
- Contention: hold vid_req=1 for 3 cycles during a CPU read -> cpu_wait_n low for 3+1 cycles, vid_valid pulses each fetch, and CPU data is correct.
- Interrupt: vb rises -> cpu_int_n=0 and stays low for 1000 cycles. m1_n=0 && iorq_n=0 releases it. An ack coinciding with a new vb edge keeps it 0.
- I/O readback: write 8'h5A to IO_PAL_BASE+3 -> pal[31:24]=8'h5A and an I/O read returns 8'h5A. A read of port 8'h10 returns 8'h00.
